// File: rtl/moore_ring_select.sv
// moore_ring_select: edge-advanced ring of NSTATE states selecting one of NSTATE data channels onto oY, with wrap pulse and saturating wrap count
module moore_ring_select #(
  parameter int WIDTH = 4,
  parameter int NSTATE = 4,
  localparam int SW = $clog2(NSTATE)
) (
  input  logic                    clk,
  input  logic                    Rst,
  input  logic                    i,
  input  logic                    iDir,
  input  logic                    iClr,
  input  logic [NSTATE*WIDTH-1:0] iData,
  output logic [WIDTH-1:0]        oY,
  output logic [SW-1:0]           oState,
  output logic                    oWrap,
  output logic [7:0]              oWrapCnt
);
  logic [SW-1:0] state, state_nx;
  logic i_prev, adv, wrap;
  always_comb begin
    adv = i & ~i_prev;
    wrap = adv & (iDir ? state == '0 : state == SW'(NSTATE - 1));
    state_nx = !adv ? state :
               iDir ? (state == '0 ? SW'(NSTATE - 1) : state - 1'b1) :
                      (state == SW'(NSTATE - 1) ? '0 : state + 1'b1);
  end
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state <= '0;
      i_prev <= 1'b0;
      oWrap <= 1'b0;
      oWrapCnt <= 8'd0;
    end else begin
      i_prev <= i;
      if (iClr) begin
        state <= '0;
        oWrap <= 1'b0;
        oWrapCnt <= 8'd0;
      end else begin
        state <= state_nx;
        oWrap <= wrap;
        if (wrap && oWrapCnt != 8'hff) oWrapCnt <= oWrapCnt + 8'd1;
      end
    end
  end
  assign oY = iData[int'(state)*WIDTH +: WIDTH];
  assign oState = state;
endmodule

// File: tb/tb_moore_ring_select.sv
// tb_moore_ring_select: randomized and directed check of moore_ring_select against a behavioural ring model
module tb_moore_ring_select;
  localparam int WIDTH = 4;
  localparam int NSTATE = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i = 1'b0;
  logic dir = 1'b0;
  logic clr = 1'b0;
  logic [NSTATE*WIDTH-1:0] data = {4'hC, 4'hB, 4'hA};
  logic [WIDTH-1:0] y;
  logic [1:0] st_o;
  logic wrap_o;
  logic [7:0] cnt_o;
  int total = 0;
  int bad = 0;
  int m_st = 0;
  int m_cnt = 0;
  bit m_wrap = 0;
  bit m_ip = 0;
  moore_ring_select #(.WIDTH(WIDTH), .NSTATE(NSTATE)) dut (
    .clk(clk), .Rst(rst), .i(i), .iDir(dir), .iClr(clr), .iData(data),
    .oY(y), .oState(st_o), .oWrap(wrap_o), .oWrapCnt(cnt_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [WIDTH-1:0] chan(input int k);
    logic [NSTATE*WIDTH-1:0] d;
    d = data;
    return d[k*WIDTH +: WIDTH];
  endfunction
  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_wrap = 0; m_ip = 0;
  endtask
  task automatic model_edge();
    if (clr) begin
      m_st = 0; m_cnt = 0; m_wrap = 0;
    end else if (i && !m_ip) begin
      m_wrap = dir ? (m_st == 0) : (m_st == NSTATE - 1);
      m_st = (m_st + (dir ? NSTATE - 1 : 1)) % NSTATE;
      if (m_wrap && m_cnt < 255) m_cnt++;
    end else m_wrap = 0;
    m_ip = i;
  endtask
  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(st_o), 32'(m_st));
    check({tag, ".y"}, 32'(y), 32'(chan(m_st)));
    check({tag, ".wrap"}, 32'(wrap_o), 32'(m_wrap));
    check({tag, ".cnt"}, 32'(cnt_o), 32'(m_cnt));
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask
  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
  endtask
  task automatic pulse(input string tag);
    i = 1'b1;
    tick(tag);
    i = 1'b0;
    tick(tag);
  endtask
  initial begin
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick("idle");
    pulse("adv1");
    async_reset();
    check("rst_y_const", 32'(y), 32'hA);
    check("rst_state_const", 32'(st_o), 32'd0);
    pulse("up1");
    check("up1_y", 32'(y), 32'hB);
    pulse("up2");
    check("up2_y", 32'(y), 32'hC);
    i = 1'b1;
    tick("up3");
    check("up3_state", 32'(st_o), 32'd0);
    check("up3_wrap", 32'(wrap_o), 32'd1);
    check("up3_cnt", 32'(cnt_o), 32'd1);
    i = 1'b0;
    tick("up3b");
    check("up3_wrap_end", 32'(wrap_o), 32'd0);
    i = 1'b1;
    for (int k = 0; k < 5; k++) tick("held");
    check("held_state", 32'(st_o), 32'd1);
    i = 1'b0;
    tick("held_end");
    clr = 1'b1;
    tick("clr");
    clr = 1'b0;
    dir = 1'b1;
    i = 1'b1;
    tick("down_wrap");
    check("down_state", 32'(st_o), 32'd2);
    check("down_y", 32'(y), 32'hC);
    check("down_wrap_pulse", 32'(wrap_o), 32'd1);
    check("down_cnt", 32'(cnt_o), 32'd1);
    i = 1'b0;
    tick("down_end");
    i = 1'b1;
    clr = 1'b1;
    tick("clr_edge");
    check("clr_edge_state", 32'(st_o), 32'd0);
    check("clr_edge_cnt", 32'(cnt_o), 32'd0);
    clr = 1'b0;
    tick("clr_edge_after");
    check("clr_lost_state", 32'(st_o), 32'd0);
    i = 1'b0;
    dir = 1'b0;
    tick("pre_sat");
    for (int k = 0; k < 300 * NSTATE; k++) pulse("sat");
    check("sat_cnt", 32'(cnt_o), 32'd255);
    data = {4'h3, 4'h2, 4'h1};
    #1;
    check("data_follow", 32'(y), 32'(chan(m_st)));
    check("data_follow_const", 32'(y), 32'h1);
    async_reset();
    i = 1'b1;
    tick("post_rst_edge");
    check("post_rst_adv", 32'(st_o), 32'd1);
    for (int k = 0; k < 600; k++) begin
      i = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) data = NSTATE*WIDTH'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset();
      else tick("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
